// File: rtl/capture_snaplen_trunc.sv
// Truncates capture-stream packets to a programmable snap length.
// The metadata length field is rewritten to the kept length.
module capture_snaplen_trunc #(
  parameter int C_M_AXIS_DATA_WIDTH  = 256,
  parameter int C_S_AXIS_DATA_WIDTH  = 256,
  parameter int C_M_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXIS_TUSER_WIDTH = 128,
  parameter int C_S_AXI_DATA_WIDTH   = 32,
  parameter int NUM_WO_REGS          = 1
) (
  input  logic                                      axi_aclk,
  input  logic                                      axi_areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]            s_axis_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]          s_axis_tstrb,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]           s_axis_tuser,
  input  logic                                      s_axis_tvalid,
  output logic                                      s_axis_tready,
  input  logic                                      s_axis_tlast,
  output logic [C_M_AXIS_DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [C_M_AXIS_DATA_WIDTH/8-1:0]          m_axis_tstrb,
  output logic [C_M_AXIS_TUSER_WIDTH-1:0]           m_axis_tuser,
  output logic                                      m_axis_tvalid,
  input  logic                                      m_axis_tready,
  output logic                                      m_axis_tlast,
  input  logic [NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:0] wo_regs,
  output logic [31:0]                               trunc_count
);

  localparam int          StrbW      = C_S_AXIS_DATA_WIDTH / 8;
  localparam logic [15:0] BeatBytes  = 16'(StrbW);
  localparam logic [15:0] MinSnap    = 16'd64;

  typedef enum logic [1:0] {StSop, StPass, StDrop} state_e;

  state_e                            state_q;
  logic [15:0]                       byte_cnt_q;
  logic [15:0]                       eff_len_q;
  logic [31:0]                       trunc_count_q;
  logic                              m_tvalid_q;
  logic                              m_tlast_q;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    m_tdata_q;
  logic [StrbW-1:0]                  m_tstrb_q;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_tuser_q;

  logic [15:0]                       snap;
  logic [15:0]                       snap_clamped;
  logic [15:0]                       pkt_len;
  logic [15:0]                       eff_len;
  logic [15:0]                       fwd_cnt;
  logic [15:0]                       rem;
  logic                              last_kept;
  logic [StrbW-1:0]                  keep_mask;
  logic [StrbW-1:0]                  out_strb;
  logic [C_S_AXIS_DATA_WIDTH-1:0]    out_data;
  logic [C_S_AXIS_TUSER_WIDTH-1:0]   out_user;
  logic                              s_fire;
  logic                              unused_wo_bits;

  assign unused_wo_bits = ^wo_regs[NUM_WO_REGS*C_S_AXI_DATA_WIDTH-1:16];

  // The snap register and packet length are only consulted on a first beat;
  // later beats reuse the length latched then, so register writes mid-packet
  // cannot disturb the packet in flight.
  always_comb begin
    snap         = wo_regs[15:0];
    pkt_len      = s_axis_tuser[15:0];
    snap_clamped = (snap < MinSnap) ? MinSnap : snap;
    if (state_q == StSop) begin
      fwd_cnt = 16'd0;
      if (snap == 16'd0) begin
        eff_len = pkt_len;
      end else begin
        eff_len = (pkt_len < snap_clamped) ? pkt_len : snap_clamped;
      end
    end else begin
      fwd_cnt = byte_cnt_q;
      eff_len = eff_len_q;
    end
    rem       = eff_len - fwd_cnt;
    last_kept = (rem <= BeatBytes);
  end

  always_comb begin
    keep_mask = '0;
    for (int i = 0; i < StrbW; i++) begin
      keep_mask[i] = (i < int'(rem));
    end
    out_strb = last_kept ? (s_axis_tstrb & keep_mask) : s_axis_tstrb;
    out_data = s_axis_tdata;
    for (int i = 0; i < StrbW; i++) begin
      if (last_kept && !out_strb[i]) begin
        out_data[8*i +: 8] = 8'h00;
      end
    end
    out_user = {s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:16], eff_len};
  end

  // Drops never need the output register, so the tail drains at full rate.
  assign s_axis_tready = (state_q == StDrop) || !m_tvalid_q || m_axis_tready;
  assign s_fire        = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge axi_aclk or posedge axi_areset) begin
    if (axi_areset) begin
      state_q       <= StSop;
      byte_cnt_q    <= 16'd0;
      eff_len_q     <= 16'd0;
      trunc_count_q <= 32'd0;
      m_tvalid_q    <= 1'b0;
      m_tlast_q     <= 1'b0;
      m_tdata_q     <= '0;
      m_tstrb_q     <= '0;
      m_tuser_q     <= '0;
    end else begin
      if (m_tvalid_q && m_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
      if (s_fire) begin
        case (state_q)
          StSop, StPass: begin
            m_tvalid_q <= 1'b1;
            m_tdata_q  <= out_data;
            m_tstrb_q  <= out_strb;
            m_tuser_q  <= out_user;
            eff_len_q  <= eff_len;
            if (last_kept) begin
              m_tlast_q  <= 1'b1;
              byte_cnt_q <= 16'd0;
              if (!s_axis_tlast) begin
                state_q       <= StDrop;
                trunc_count_q <= trunc_count_q + 32'd1;
              end else begin
                state_q <= StSop;
              end
            end else if (s_axis_tlast) begin
              m_tlast_q  <= 1'b1;
              byte_cnt_q <= 16'd0;
              state_q    <= StSop;
            end else begin
              m_tlast_q  <= 1'b0;
              byte_cnt_q <= fwd_cnt + BeatBytes;
              state_q    <= StPass;
            end
          end
          StDrop: begin
            if (s_axis_tlast) begin
              state_q <= StSop;
            end
          end
          default: state_q <= StSop;
        endcase
      end
    end
  end

  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tstrb  = m_tstrb_q;
  assign m_axis_tuser  = m_tuser_q;
  assign trunc_count   = trunc_count_q;

endmodule
